clk_rst_seq: RTL and testbench

CLK_RST_SEQ -- requirements
Module: clk_rst_seq

---
 rtl/clk_rst_seq.sv | 116 +++++++++++
 tb/tb_clk_rst_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_seq.sv
// Reset sequencer (synchronise, stretch, release) driving NCH independent clock dividers.
// Each divider emits a one-cycle tick and a registered 50% clock of period 2*D.
`timescale 1ns/1ps
module clk_rst_seq #(
  parameter int NCH         = 2,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 16,
  parameter int DIV_RST     = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NCH*DIV_W-1:0] div_i,
  input  logic [NCH-1:0]       div_load_i,
  input  logic [NCH-1:0]       en_i,
  output logic [NCH-1:0]       tick_o,
  output logic [NCH-1:0]       clk_o,
  output logic                 rst_n_o,
  output logic                 ready_o
);

  typedef enum logic [1:0] {ST_RESET, ST_SYNC, ST_HOLD, ST_RUN} state_e;

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);

  state_e                   state_q;
  logic [SYNC_STAGES-1:0]   sync_q;
  logic [HOLD_W-1:0]        hold_q;
  logic                     run_q;

  // Release sequence: edge 1 leaves RESET, edge SYNC_STAGES leaves SYNC,
  // RST_CYCLES edges later the design reset is released.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_RESET;
      sync_q  <= '0;
      hold_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      case (state_q)
        ST_RESET: state_q <= ST_SYNC;
        ST_SYNC:  if (sync_q[SYNC_STAGES-2]) state_q <= ST_HOLD;
        ST_HOLD: begin
          if (sync_q[SYNC_STAGES-1]) begin
            if (hold_q == HOLD_W'(RST_CYCLES - 1)) begin
              state_q <= ST_RUN;
              run_q   <= 1'b1;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rst_n_o = run_q;
  assign ready_o = run_q;

  logic [DIV_W-1:0] cnt_q   [NCH];
  logic [DIV_W-1:0] act_q   [NCH];
  logic [DIV_W-1:0] shd_q   [NCH];
  logic [DIV_W-1:0] shd_d   [NCH];
  logic [DIV_W-1:0] eff_div [NCH];
  logic [NCH-1:0]   clk_q;
  logic [NCH-1:0]   run_en;
  logic [NCH-1:0]   tick;

  // A load on the terminal cycle bypasses the shadow so the new value governs
  // the very next period; a divisor of 0 runs as 1.
  always_comb begin
    // NOTE: every element is written on every pass, so no latch can be inferred.
    for (int k = 0; k < NCH; k++) begin
      shd_d[k]   = div_load_i[k] ? div_i[k*DIV_W +: DIV_W] : shd_q[k];
      eff_div[k] = (act_q[k] == '0) ? DIV_W'(1) : act_q[k];
      run_en[k]  = run_q & en_i[k];
      tick[k]    = run_en[k] & (cnt_q[k] == eff_div[k] - DIV_W'(1));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: these per-channel arrays are small register banks, not RAM, so
      // they take the asynchronous reset like any other flop.
      for (int k = 0; k < NCH; k++) begin
        cnt_q[k] <= '0;
        act_q[k] <= DIV_W'(DIV_RST);
        shd_q[k] <= DIV_W'(DIV_RST);
      end
      clk_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        shd_q[k] <= shd_d[k];
        if (!run_en[k]) begin
          cnt_q[k] <= '0;
          clk_q[k] <= 1'b0;
          act_q[k] <= shd_d[k];
        end else if (tick[k]) begin
          cnt_q[k] <= '0;
          clk_q[k] <= ~clk_q[k];
          act_q[k] <= shd_d[k];
        end else begin
          cnt_q[k] <= cnt_q[k] + DIV_W'(1);
        end
      end
    end
  end

  assign tick_o = tick;
  assign clk_o  = clk_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Randomised bench for clk_rst_seq: a cycle-level reference model pushes the
// expected outputs per cycle; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_clk_rst_seq;

  localparam int NCH     = 2;
  localparam int DIV_W   = 16;
  localparam int S       = 2;
  localparam int R       = 16;
  localparam int DIV_RST = 1;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic [NCH*DIV_W-1:0] div_i = '0;
  logic [NCH-1:0]       div_load_i = '0;
  logic [NCH-1:0]       en_i = '0;
  logic [NCH-1:0]       tick_o;
  logic [NCH-1:0]       clk_o;
  logic                 rst_n_o;
  logic                 ready_o;

  clk_rst_seq #(
    .NCH(NCH), .DIV_W(DIV_W), .SYNC_STAGES(S), .RST_CYCLES(R), .DIV_RST(DIV_RST)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_i      (div_i),
    .div_load_i (div_load_i),
    .en_i       (en_i),
    .tick_o     (tick_o),
    .clk_o      (clk_o),
    .rst_n_o    (rst_n_o),
    .ready_o    (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           rst_n;
    logic           ready;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] dclk;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // Reference model: edges since release decide readiness; each channel is
  // described by the absolute cycle of its next tick and the number of ticks
  // seen since it became active (clk_o is that count's parity).
  initial begin : model
    int unsigned rel;
    longint      cyc;
    int          latest    [NCH];
    int          dact      [NCH];
    int          nticks    [NCH];
    longint      next_tick [NCH];
    bit          s_act     [NCH];
    bit          s_tick    [NCH];
    exp_t        e;
    rel = 0;
    cyc = 0;
    for (int k = 0; k < NCH; k++) begin
      latest[k] = DIV_RST; dact[k] = DIV_RST; nticks[k] = 0;
      next_tick[k] = 0; s_act[k] = 1'b0; s_tick[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      if (resetn) begin
        if (rel < 1000) rel++;
        for (int k = 0; k < NCH; k++) begin
          int raw;
          raw = div_load_i[k] ? int'(div_i[k*DIV_W +: DIV_W]) : latest[k];
          latest[k] = raw;
          if (s_tick[k]) begin
            nticks[k]++;
            dact[k] = eff(raw);
            next_tick[k] = cyc + dact[k];
          end else if (!s_act[k]) begin
            nticks[k] = 0;
            dact[k] = eff(raw);
            next_tick[k] = cyc + dact[k];
          end
        end
      end
      cyc++;
      #3;
      if (!resetn) begin
        rel = 0;
        for (int k = 0; k < NCH; k++) begin
          latest[k] = DIV_RST; dact[k] = DIV_RST; nticks[k] = 0;
        end
      end
      e.ready = resetn && (rel >= S + R);
      e.rst_n = e.ready;
      for (int k = 0; k < NCH; k++) begin
        s_act[k]  = e.ready && en_i[k];
        s_tick[k] = s_act[k] && (cyc == next_tick[k]);
        e.tick[k] = s_tick[k];
        e.dclk[k] = (nticks[k] % 2) == 1;
      end
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
    end else begin
      mon_e = exp_q.pop_front();
      check("rst_n_o", 32'(rst_n_o), 32'(mon_e.rst_n));
      check("ready_o", 32'(ready_o), 32'(mon_e.ready));
      check("tick_o",  32'(tick_o),  32'(mon_e.tick));
      check("clk_o",   32'(clk_o),   32'(mon_e.dclk));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic load(input int ch, input int val);
    div_i[ch*DIV_W +: DIV_W] = DIV_W'(val);
    div_load_i[ch] = 1'b1;
    cyc(1);
    div_load_i[ch] = 1'b0;
  endtask

  // Counts rising edges from a release done between edges; edge 1 is the next one.
  task automatic wait_ready(input string name);
    int got;
    got = 0;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (ready_o === 1'b1) begin
        got = e;
        break;
      end
    end
    #1;
    check(name, 32'(got), 32'(S + R));
  endtask

  initial begin : stim
    int first;
    cyc(3);
    resetn = 1'b1;
    wait_ready("ready_edge_por");

    // ch0 D=1, ch1 D=3
    div_i = {16'd3, 16'd1};
    div_load_i = 2'b11;
    cyc(1);
    div_load_i = 2'b00;
    en_i = 2'b11;
    cyc(30);

    // ch0 D=4, reload 2 at count 1
    en_i[0] = 1'b0;
    load(0, 4);
    cyc(1);
    en_i[0] = 1'b1;
    cyc(1);
    load(0, 2);
    cyc(12);
    // ch0 D=4, reload 2 exactly at count 3 (terminal)
    en_i[0] = 1'b0;
    load(0, 4);
    cyc(1);
    en_i[0] = 1'b1;
    cyc(3);
    load(0, 2);
    cyc(8);

    // divisor 0 runs as 1
    load(0, 0);
    cyc(10);

    // disable mid-period for 5 cycles
    load(0, 3);
    cyc(7);
    en_i[0] = 1'b0;
    cyc(5);
    en_i[0] = 1'b1;
    cyc(10);

    // random loads, divisors and enables
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < NCH; k++) begin
        if ($urandom_range(0, 5) == 0) begin
          div_i[k*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 6));
          div_load_i[k] = 1'b1;
        end else begin
          div_load_i[k] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) en_i[k] = ~en_i[k];
      end
      cyc(1);
    end
    div_load_i = '0;

    // one-cycle reset pulse during RUN
    en_i = 2'b11;
    cyc(5);
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    wait_ready("ready_edge_after_pulse");
    cyc(10);

    // reset glitch at edge 10 of the release sequence restarts the count
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    cyc(10);
    resetn = 1'b0;
    cyc(1);
    resetn = 1'b1;
    wait_ready("ready_edge_after_glitch");
    cyc(5);

    // all-ones divisor on ch1: first tick on the 65535th enabled cycle
    en_i = 2'b00;
    div_i = {16'hFFFF, 16'd1};
    div_load_i = 2'b11;
    cyc(1);
    div_load_i = 2'b00;
    cyc(1);
    en_i = 2'b10;
    first = 0;
    for (int e = 1; e <= 70000; e++) begin
      @(negedge clk);
      if (tick_o[1] === 1'b1) begin
        first = e;
        break;
      end
    end
    check("ch1_first_tick_ffff", 32'(first), 32'd65535);
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
